// File: rtl/clock_div_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
// Helpers work in a fixed 32-bit domain so channels of any WIDTH up to 31 can share them.
package clock_div_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_W         = 32;

  // A programmed divisor of 0 behaves as 1 (output held high, tick every cycle).
  function automatic logic [MAX_W-1:0] eff_div(input logic [MAX_W-1:0] d);
    return (d == '0) ? MAX_W'(1) : d;
  endfunction

  // High-phase length: ceil(D/2), so odd divisors spend the extra cycle high.
  function automatic logic [MAX_W-1:0] half_div(input logic [MAX_W-1:0] d);
    return (d + MAX_W'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: phase counter, staged/active divisor pair and registered outputs.
// Divisor changes are deferred to phase 0 so no period is ever truncated.
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_pending,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_staged;
  logic             r_started;
  logic             r_pending;
  logic             r_clk;
  logic             r_tick;

  logic [MAX_W-1:0] w_d_act;
  logic [MAX_W-1:0] w_h_act;
  logic             w_wrap;
  logic             w_boundary;
  logic             w_high_next;
  logic [WIDTH-1:0] w_phase_inc;

  assign w_d_act     = eff_div(MAX_W'(r_active));
  assign w_h_act     = half_div(w_d_act);
  assign w_wrap      = (MAX_W'(r_phase) == (w_d_act - MAX_W'(1)));
  assign w_boundary  = !r_started || sync || w_wrap;
  assign w_phase_inc = r_phase + WIDTH'(1);
  assign w_high_next = ((MAX_W'(r_phase) + MAX_W'(1)) < w_h_act);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= '0;
      r_active  <= WIDTH'(RESET_DIV);
      r_staged  <= WIDTH'(RESET_DIV);
      r_started <= 1'b0;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      if (div_load) begin
        r_staged <= div_in;
      end
      if (enable) begin
        r_started <= 1'b1;
        if (w_boundary) begin
          // Phase 0 is always inside the high half since H >= 1 for any divisor.
          r_phase  <= '0;
          r_active <= r_staged;
          r_clk    <= 1'b1;
          r_tick   <= 1'b1;
        end else begin
          r_phase  <= w_phase_inc;
          r_clk    <= w_high_next;
          r_tick   <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
      // A load on a boundary edge stays pending: the older staged value is what got applied.
      if (div_load) begin
        r_pending <= 1'b1;
      end else if (enable && w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign div_pending = r_pending;
  assign clk_out     = r_clk;
  assign tick        = r_tick;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: one independent channel per divisor slice,
// with a shared enable and a shared sync that restarts every channel at phase 0.
module clock_divider_prog
  import clock_div_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sync,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_load,
  output logic [CHANNELS-1:0]       div_pending,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_div_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sync        (sync),
      .div_in      (div_in[g*WIDTH +: WIDTH]),
      .div_load    (div_load[g]),
      .div_pending (div_pending[g]),
      .clk_out     (clk_out[g]),
      .tick        (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: reference model feeds an expected queue each cycle,
// plus a vector table for the first periods and directed corner-case sequences.
module tb_clock_divider_prog;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int EW = 3 * CH;

  logic          clk = 1'b0;
  logic          reset, enable, sync;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0] div_load, div_pending, clk_out, tick;

  clock_divider_prog #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync),
    .div_in(div_in), .div_load(div_load), .div_pending(div_pending),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];

  int m_phase[CH], m_active[CH], m_staged[CH];
  bit m_started[CH], m_pend[CH], m_clk[CH], m_tick[CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit sy,
                            input logic [CH-1:0] ld, input logic [CH*W-1:0] din);
    for (int c = 0; c < CH; c++) begin
      bit bnd;
      int d;
      if (rst) begin
        m_phase[c] = 0; m_active[c] = 4; m_staged[c] = 4; m_started[c] = 0;
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        continue;
      end
      bnd = 0;
      d = eff(m_active[c]);
      if (en) begin
        bnd = !m_started[c] || sy || (m_phase[c] == d - 1);
        if (bnd) begin
          m_active[c] = m_staged[c];
          m_phase[c] = 0;
        end else begin
          m_phase[c] = m_phase[c] + 1;
        end
        m_started[c] = 1;
        d = eff(m_active[c]);
        m_clk[c]  = (m_phase[c] < (d + 1) / 2);
        m_tick[c] = (m_phase[c] == 0);
      end else begin
        m_tick[c] = 0;
      end
      if (ld[c]) begin
        m_staged[c] = int'(din[c*W +: W]);
        m_pend[c] = 1;
      end else if (bnd) begin
        m_pend[c] = 0;
      end
    end
  endtask

  // Drive one cycle at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input bit rst, input bit en, input bit sy,
                      input logic [CH-1:0] ld, input logic [CH*W-1:0] din);
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    @(negedge clk);
    reset = rst; enable = en; sync = sy; div_load = ld; div_in = din;
    model_step(rst, en, sy, ld, din);
    for (int c = 0; c < CH; c++) begin
      e[c] = m_tick[c]; e[CH+c] = m_clk[c]; e[2*CH+c] = m_pend[c];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {div_pending, clk_out, tick};
    if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
    else check("sb_outputs", 32'(got), 32'(exp_q.pop_front()));
  endtask

  function automatic logic [CH*W-1:0] pack2(input int d0, input int d1);
    return {W'(d1), W'(d0)};
  endfunction

  typedef struct {
    logic ld0;
    logic exp_clk;
    logic exp_tick;
    logic exp_pend;
  } vec_t;

  vec_t tbl[15];
  logic [0:14] clk_pat, tick_pat, pend_pat;

  initial begin
    reset = 1'b1; enable = 1'b0; sync = 1'b0; div_load = '0; div_in = '0;
    clk_pat  = 15'b110011100111001;
    tick_pat = 15'b100010000100001;
    pend_pat = 15'b001100000000000;
    for (int i = 0; i < 15; i++)
      tbl[i] = '{ld0: (i == 2), exp_clk: clk_pat[i], exp_tick: tick_pat[i], exp_pend: pend_pat[i]};

    step(1, 1, 0, 2'b00, '0);
    step(1, 1, 1, 2'b11, pack2(7, 7));
    check("reset_outputs", 32'({div_pending, clk_out, tick}), 32'd0);

    // RESET_DIV=4 pattern, then divisor 5 loaded on ch0 at edge 2.
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, {1'b0, tbl[i].ld0}, pack2(5, 0));
      check("tbl_clk0",  32'(clk_out[0]),     32'(tbl[i].exp_clk));
      check("tbl_tick0", 32'(tick[0]),        32'(tbl[i].exp_tick));
      check("tbl_pend0", 32'(div_pending[0]), 32'(tbl[i].exp_pend));
    end

    // Ch1 divisor 1, then 0: both must keep clk_out high with a tick every cycle.
    step(0, 1, 0, 2'b10, pack2(0, 1));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b00, '0);
    step(0, 1, 0, 2'b10, pack2(0, 0));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 2'b00, '0);
      check("div01_clk1", 32'(clk_out[1]), 32'd1);
      check("div01_tick1", 32'(tick[1]), 32'd1);
    end

    // Stage 3 on ch0, then load 6 exactly on a boundary edge.
    step(0, 1, 0, 2'b01, pack2(3, 0));
    for (int i = 0; i < 20 && !(m_phase[0] == eff(m_active[0]) - 1); i++)
      step(0, 1, 0, 2'b00, '0);
    check("bnd_reached", 32'(m_phase[0] == eff(m_active[0]) - 1), 32'd1);
    step(0, 1, 0, 2'b01, pack2(6, 0));
    check("bnd_load_tick0", 32'(tick[0]), 32'd1);
    check("bnd_load_pend0", 32'(div_pending[0]), 32'd1);
    step(0, 1, 0, 2'b00, '0);
    step(0, 1, 0, 2'b00, '0);
    check("bnd_old_low0", 32'(clk_out[0]), 32'd0);
    check("bnd_pend_held", 32'(div_pending[0]), 32'd1);
    step(0, 1, 0, 2'b00, '0);
    check("bnd_new_tick0", 32'(tick[0]), 32'd1);
    check("bnd_pend_clr", 32'(div_pending[0]), 32'd0);

    // Ch0 D=3, ch1 D=7, then sync with pending loads mid-period.
    step(0, 1, 0, 2'b11, pack2(3, 7));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 2'b00, '0);
    step(0, 1, 0, 2'b00, '0);
    step(0, 1, 0, 2'b11, pack2(2, 5));
    step(0, 0, 1, 2'b00, '0);
    check("sync_ignored_pend", 32'(div_pending), 32'd3);
    step(0, 1, 1, 2'b00, '0);
    check("sync_tick", 32'(tick), 32'd3);
    check("sync_clk", 32'(clk_out), 32'd3);
    check("sync_pend", 32'(div_pending), 32'd0);

    // Freeze for 3 cycles during ch1's high half.
    step(0, 1, 0, 2'b00, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 2'b00, '0);
      check("freeze_clk1", 32'(clk_out[1]), 32'd1);
      check("freeze_tick", 32'(tick), 32'd0);
    end
    for (int i = 0; i < 8; i++) step(0, 1, 0, 2'b00, '0);

    // Reset mid-period with a pending load.
    step(0, 1, 0, 2'b01, pack2(9, 0));
    step(0, 1, 0, 2'b00, '0);
    step(1, 1, 1, 2'b11, pack2(8, 8));
    check("midreset_out", 32'({div_pending, clk_out, tick}), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2'b00, '0);

    // Random traffic.
    for (int i = 0; i < 120; i++) begin
      logic [CH-1:0] ld;
      ld = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           ld, pack2($urandom_range(0, 9), $urandom_range(0, 9)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
